// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: fetch state encoding, word/PC widths, PC step and the
// {pc, instr} entry carried through the fetch buffer.
package fetch_unit_pkg;

    localparam int INSTR_W    = 32;
    localparam int PC_W       = 32;
    localparam int FIFO_DEPTH = 2;
    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction memory request/ack, decoder valid/ready, branch redirect.
// master = fetch unit side, slave = memory/decoder/branch side.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               dec_valid;
    logic [INSTR_W-1:0] dec_instr;
    logic [PC_W-1:0]    dec_pc;
    logic               dec_ready;
    logic               br_taken;
    logic [PC_W-1:0]    br_pc;
    logic [23:0]        br_offset;

    modport master (
        output imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
        input  imem_ack, imem_rdata, dec_ready, br_taken, br_pc, br_offset
    );

    modport slave (
        input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
        output imem_ack, imem_rdata, dec_ready, br_taken, br_pc, br_offset
    );

endinterface

// File: rtl/fetch_fifo.sv
// Purpose: 2-entry {pc, instr} buffer between instruction memory and decoder, with flush.
// Latency: a push is visible at the head on the next cycle; head is driven from registers only.
// Backpressure: none internally; the caller's credit scheme guarantees no push while full.
module fetch_fifo
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    output fetch_entry_t head_dat,
    output logic         head_vld,
    output logic [1:0]   count
);

    fetch_entry_t slot [FIFO_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         push_ok;
    logic         pop_ok;

    assign push_ok  = push & (cnt != 2'd2);
    assign pop_ok   = pop & (cnt != 2'd0);
    assign head_dat = slot[rd_ptr];
    assign head_vld = (cnt != 2'd0);
    assign count    = cnt;

    // Slots are cleared on reset so the decoder sees zero pc/instr while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            cnt     <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push_ok) begin
                slot[wr_ptr] <= push_dat;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Purpose: instruction fetch with credit-limited memory requests, 2-entry buffer and branch redirect.
// Latency: dec_valid rises the cycle after an accepted imem ack; 1 instr/cycle with zero-wait memory.
// Backpressure: dec_ready low holds the head; requests stop once buffer + outstanding reaches 2.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
)
(
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    fetch_state_t    state;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] req_addr;
    logic            req_q;

    logic            ack;
    logic            push;
    logic            pop;
    logic            credit;
    logic [1:0]      occ;
    logic [1:0]      occ_after;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] br_target;
    fetch_entry_t    push_dat;
    fetch_entry_t    head;
    logic            head_vld;

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = req_addr;
    assign bus.dec_valid = head_vld;
    assign bus.dec_instr = head.instr;
    assign bus.dec_pc    = head.pc;

    assign push_dat = {req_addr, bus.imem_rdata};

    always_comb begin
        ack       = req_q & bus.imem_ack;
        // Data returning for a request issued before a redirect (DROP) is never buffered.
        push      = ack & (state == REQ) & ~bus.br_taken;
        pop       = head_vld & bus.dec_ready & ~bus.br_taken;
        occ_after = occ + {1'b0, push} - {1'b0, pop};
        credit    = (occ_after < 2'd2);
        pc_next   = fetch_pc + PC_INC;
        // Branch addresses are word aligned, so the target stays word aligned too.
        br_target = bus.br_pc + 32'd8 + {{6{bus.br_offset[23]}}, bus.br_offset, 2'b00};
    end

    fetch_fifo u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bus.br_taken),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head),
        .head_vld (head_vld),
        .count    (occ)
    );

    // In REQ, fetch_pc equals the outstanding address; in DROP it holds the redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            req_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.br_taken) begin
                        fetch_pc <= br_target;
                        req_addr <= br_target;
                        req_q    <= 1'b1;
                        state    <= REQ;
                    end else if (credit) begin
                        req_addr <= fetch_pc;
                        req_q    <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (bus.br_taken) begin
                        fetch_pc <= br_target;
                        if (ack) begin
                            req_addr <= br_target;
                        end else begin
                            state <= DROP;
                        end
                    end else if (ack) begin
                        fetch_pc <= pc_next;
                        req_addr <= pc_next;
                        if (!credit) begin
                            req_q <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (bus.br_taken) begin
                        fetch_pc <= br_target;
                    end
                    if (ack) begin
                        req_addr <= bus.br_taken ? br_target : fetch_pc;
                        state    <= REQ;
                    end
                end
                default: begin
                    req_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responder with programmable wait states,
// expected-pc queue checked against every decoder handshake, plus a wrap-around instance.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk;
    logic rst_n;
    logic rst2_n;

    fetch_unit_if bus();
    fetch_unit_if bus2();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int lat      = 0;
    int wcnt     = 0;
    logic        prev_req  = 1'b0;
    logic        prev_ack  = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] exp_q[$];
    logic        found;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_restart(input logic [31:0] pc0);
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(pc0 + 32'(4 * i));
    endtask

    // Called at a negedge: scores the handshake the coming posedge will perform.
    task automatic tick();
        logic [31:0] e;
        if (rst_n && bus.dec_valid && bus.dec_ready && !bus.br_taken) begin
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_extra: observed pc %h expected no entry", bus.dec_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", bus.dec_pc, e);
                chk("sb_instr", bus.dec_instr, mem_word(e));
            end
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && prev_req && !prev_ack && bus.imem_req)
            chk("addr_stable", bus.imem_addr, prev_addr);
        if (!rst_n || !bus.imem_req) begin
            bus.imem_ack = 1'b0;
            wcnt = 0;
        end else if (wcnt >= lat) begin
            bus.imem_ack = 1'b1;
            wcnt = 0;
        end else begin
            bus.imem_ack = 1'b0;
            wcnt++;
        end
        bus.imem_rdata = bus.imem_ack ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;
        prev_req  = rst_n & bus.imem_req;
        prev_ack  = bus.imem_ack;
        prev_addr = bus.imem_addr;
    end

    always @(negedge clk) begin
        bus2.imem_ack   = bus2.imem_req;
        bus2.imem_rdata = mem_word(bus2.imem_addr);
    end

    initial begin
        rst_n = 1'b0;
        rst2_n = 1'b0;
        bus.dec_ready = 1'b0;
        bus.br_taken = 1'b0;
        bus.br_pc = 32'h0;
        bus.br_offset = 24'h0;
        bus2.dec_ready = 1'b1;
        bus2.br_taken = 1'b0;
        bus2.br_pc = 32'h0;
        bus2.br_offset = 24'h0;
        repeat (3) @(negedge clk);

        chk("rst_req", 32'(bus.imem_req), 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", 32'(bus.dec_valid), 32'h0);
        chk("rst_instr", bus.dec_instr, 32'h0);
        chk("rst_pc", bus.dec_pc, 32'h0);

        // Reset release, zero-wait memory, decoder always ready.
        sb_restart(32'h0);
        bus.dec_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        chk("first_req", 32'(bus.imem_req), 32'h1);
        chk("first_addr", bus.imem_addr, 32'h0);
        chk("first_valid", 32'(bus.dec_valid), 32'h0);
        tick();
        chk("c2_valid", 32'(bus.dec_valid), 32'h1);
        chk("c2_pc", bus.dec_pc, 32'h0);
        tick();
        chk("c3_pc", bus.dec_pc, 32'h4);
        tick();
        chk("c4_pc", bus.dec_pc, 32'h8);

        // Decoder stall: buffer fills, requests stop, nothing lost afterwards.
        bus.dec_ready = 1'b0;
        repeat (5) tick();
        chk("stall_req", 32'(bus.imem_req), 32'h0);
        chk("stall_valid", 32'(bus.dec_valid), 32'h1);
        chk("stall_pc", bus.dec_pc, 32'h8);
        bus.dec_ready = 1'b1;
        repeat (6) tick();

        // Branch with no request outstanding: target 0x10+8-8 = 0x10.
        bus.dec_ready = 1'b0;
        repeat (4) tick();
        chk("idle_before_br", 32'(bus.imem_req), 32'h0);
        bus.br_pc = 32'h10;
        bus.br_offset = 24'hFFFFFE;
        bus.br_taken = 1'b1;
        sb_restart(32'h10);
        tick();
        bus.br_taken = 1'b0;
        chk("br_idle_req", 32'(bus.imem_req), 32'h1);
        chk("br_idle_addr", bus.imem_addr, 32'h10);
        chk("br_idle_valid", 32'(bus.dec_valid), 32'h0);
        bus.dec_ready = 1'b1;
        repeat (5) tick();

        // Branch while the request to 0x8 waits 3 more cycles; target 0x100+8+12 = 0x114.
        lat = 3;
        tick();
        bus.br_pc = 32'h0;
        bus.br_offset = 24'hFFFFFE;
        bus.br_taken = 1'b1;
        sb_restart(32'h0);
        tick();
        bus.br_taken = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.imem_req && bus.imem_addr == 32'h8) found = 1'b1;
            else tick();
        end
        chk("wait_req8", 32'(found), 32'h1);
        bus.br_pc = 32'h100;
        bus.br_offset = 24'h000003;
        bus.br_taken = 1'b1;
        sb_restart(32'h114);
        tick();
        bus.br_taken = 1'b0;
        chk("drop_req", 32'(bus.imem_req), 32'h1);
        chk("drop_addr", bus.imem_addr, 32'h8);
        chk("drop_valid", 32'(bus.dec_valid), 32'h0);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (bus.imem_addr != 32'h8) found = 1'b1;
        end
        chk("drop_done", 32'(found), 32'h1);
        chk("drop_target", bus.imem_addr, 32'h114);
        repeat (12) tick();

        // Asynchronous reset with one buffered entry and a request in flight.
        bus.dec_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (bus.dec_valid && bus.imem_req) found = 1'b1;
            else tick();
        end
        chk("wait_busy", 32'(found), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(bus.imem_req), 32'h0);
        chk("arst_addr", bus.imem_addr, 32'h0);
        chk("arst_valid", 32'(bus.dec_valid), 32'h0);
        chk("arst_instr", bus.dec_instr, 32'h0);
        chk("arst_pc", bus.dec_pc, 32'h0);
        @(negedge clk);
        sb_restart(32'h0);
        lat = 0;
        bus.dec_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        chk("refetch_req", 32'(bus.imem_req), 32'h1);
        chk("refetch_addr", bus.imem_addr, 32'h0);
        tick();
        chk("refetch_pc", bus.dec_pc, 32'h0);

        // Address wrap from RESET_PC = 0xFFFFFFF8.
        rst2_n = 1'b1;
        tick();
        chk("wrap_a0", bus2.imem_addr, 32'hFFFF_FFF8);
        tick();
        chk("wrap_a1", bus2.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc0", bus2.dec_pc, 32'hFFFF_FFF8);
        tick();
        chk("wrap_a2", bus2.imem_addr, 32'h0000_0000);
        chk("wrap_pc1", bus2.dec_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc2", bus2.dec_pc, 32'h0000_0000);
        chk("wrap_instr2", bus2.dec_instr, mem_word(32'h0));
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
